// File: rtl/deco_pkg.sv
// Shared definitions for the DECO soft-decision Viterbi decoder.
// Holds the controller state encoding, the default geometry constants, the
// path-metric width, the encoder output table and the branch-metric helper.
// Optional feature macro: DECO_SOFT_EN (consumed in deco.sv).
package deco_pkg;

  localparam int DECO_WORD_W  = 21;
  localparam int DECO_SYM_W   = 4;
  localparam int DECO_N_STEPS = 7;
  localparam int DECO_N_WORDS = 4;
  localparam int N_STATES     = 4;
  localparam int MET_W        = 10;

  localparam logic signed [MET_W-1:0] METRIC_INIT = -10'sd256;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ACS,
    TRACE,
    DONE
  } state_t;

  // Encoder outputs {c2,c1,c0} indexed by {prev_state[1:0], u}.
  // prev_state = {m1,m0}: c0 = u, c1 = u^m1^m0, c2 = u^m0.
  localparam logic [7:0][2:0] ENC_TABLE = {
    3'b011, 3'b100, 3'b101, 3'b010,
    3'b001, 3'b110, 3'b111, 3'b000
  };

  // Correlation metric: each symbol counts positive when the expected bit
  // is 1 and negative when it is 0, so larger is a better match.
  function automatic logic signed [MET_W-1:0] branch_metric(
    input logic [2:0]              code,
    input logic signed [MET_W-1:0] s_sys,
    input logic signed [MET_W-1:0] s_p1,
    input logic signed [MET_W-1:0] s_p2
  );
    logic signed [MET_W-1:0] acc;
    acc = code[0] ? s_sys : -s_sys;
    acc = acc + (code[1] ? s_p1 : -s_p1);
    acc = acc + (code[2] ? s_p2 : -s_p2);
    return acc;
  endfunction

endpackage

// File: rtl/deco_acs_unit.sv
// Single-state add-compare-select for the 4-state trellis.
// Ports:
//   sym_sys, sym_p1, sym_p2 : mapped symbol values for the current step
//   pm_lo, pm_hi            : path metrics of the two predecessor states
//   pm_new                  : surviving path metric for this state
//   decision                : 1 when the higher-index predecessor survives
// STATE selects which trellis state this instance serves.
module deco_acs_unit
  import deco_pkg::*;
#(
  parameter logic [1:0] STATE = 2'd0
) (
  input  logic signed [MET_W-1:0] sym_sys,
  input  logic signed [MET_W-1:0] sym_p1,
  input  logic signed [MET_W-1:0] sym_p2,
  input  logic signed [MET_W-1:0] pm_lo,
  input  logic signed [MET_W-1:0] pm_hi,
  output logic signed [MET_W-1:0] pm_new,
  output logic                    decision
);

  // State {u,m1} is reached from {m1,0} and {m1,1} with input u = STATE[1].
  localparam logic [2:0] CODE_LO = ENC_TABLE[{STATE[0], 1'b0, STATE[1]}];
  localparam logic [2:0] CODE_HI = ENC_TABLE[{STATE[0], 1'b1, STATE[1]}];

  logic signed [MET_W-1:0] cand_lo;
  logic signed [MET_W-1:0] cand_hi;

  // Strict greater-than keeps the lower-index predecessor on a tie.
  always_comb begin
    cand_lo  = pm_lo + branch_metric(CODE_LO, sym_sys, sym_p1, sym_p2);
    cand_hi  = pm_hi + branch_metric(CODE_HI, sym_sys, sym_p1, sym_p2);
    decision = (cand_hi > cand_lo);
    pm_new   = decision ? cand_hi : cand_lo;
  end

endmodule

// File: rtl/deco.sv
// DECO: soft-decision Viterbi decoder for a terminated rate-1/3, 4-state
// convolutional code. An 84-bit frame arrives as four 21-bit words, is
// decoded over 7 trellis steps (5 info + 2 tail) and the 5 info bits are
// presented on data_o together with a one-cycle done_o pulse.
// Ports:
//   clk_p_i   : clock, rising edge
//   reset_n_i : asynchronous active-low reset
//   start_i   : frame-load strobe, one word captured per high cycle
//   data_i    : frame word
//   data_o    : decoded info bits, held until the next result
//   done_o    : one-cycle result-valid pulse
// Macro DECO_SOFT_EN: when defined, symbols are used at full soft value;
// otherwise each symbol is sliced to +1/-1 before metric computation.
module deco
  import deco_pkg::*;
#(
  parameter int WORD_W  = DECO_WORD_W,
  parameter int SYM_W   = DECO_SYM_W,
  parameter int N_STEPS = DECO_N_STEPS
) (
  input  logic              clk_p_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [N_STEPS-3:0] data_o,
  output logic              done_o
);

  localparam int INFO_W  = N_STEPS - 2;
  localparam int STEP_W  = 3 * SYM_W;
  localparam int FRAME_W = DECO_N_WORDS * WORD_W;

  localparam logic [2:0] WORDS_FULL = 3'(DECO_N_WORDS);
  localparam logic [2:0] STEP_LAST  = 3'(N_STEPS - 1);

  localparam logic signed [MET_W-1:0] POS_ONE = 10'sd1;
  localparam logic signed [MET_W-1:0] NEG_ONE = -10'sd1;

  state_t state;
  state_t next_state;

  logic [2:0]              word_cnt;
  logic [2:0]              step;
  logic [FRAME_W-1:0]      frame;
  logic [STEP_W-1:0]       step_bits;
  logic signed [MET_W-1:0] sym_m   [3];
  logic signed [MET_W-1:0] pm      [N_STATES];
  logic signed [MET_W-1:0] pm_next [N_STATES];
  logic [N_STATES-1:0]     dec;
  logic [N_STATES-1:0]     surv    [N_STEPS];
  logic [INFO_W-1:0]       info_bits;
  logic [1:0]              trace_state;

  function automatic logic signed [MET_W-1:0] map_sym(input logic signed [SYM_W-1:0] v);
`ifdef DECO_SOFT_EN
    return MET_W'(v);
`else
    return (v >= 0) ? POS_ONE : NEG_ONE;
`endif
  endfunction

  // State register.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= next_state;
  end

  // Next-state logic. A load that ends before all four words arrive is
  // dropped silently; extra start cycles after a full load are ignored.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_i) next_state = LOAD;
      LOAD:    if (!start_i) next_state = (word_cnt == WORDS_FULL) ? ACS : IDLE;
      ACS:     if (step == STEP_LAST) next_state = TRACE;
      TRACE:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Frame capture: word k lands at frame[21k +: 21] in arrival order.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      word_cnt <= '0;
      frame    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            frame[WORD_W-1:0] <= data_i;
            word_cnt          <= 3'd1;
          end else begin
            word_cnt <= '0;
          end
        end
        LOAD: begin
          if (start_i && (word_cnt != WORDS_FULL)) begin
            frame[word_cnt*WORD_W +: WORD_W] <= data_i;
            word_cnt                         <= word_cnt + 3'd1;
          end
        end
        default: word_cnt <= '0;
      endcase
    end
  end

  // Symbols for the current trellis step, mapped according to DECO_SOFT_EN.
  assign step_bits = frame[step*STEP_W +: STEP_W];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sym_m[i] = map_sym(step_bits[i*SYM_W +: SYM_W]);
    end
  end

  // One ACS per trellis state; predecessors of {u,m1} are {m1,0} and {m1,1}.
  for (genvar g = 0; g < N_STATES; g++) begin : g_acs
    deco_acs_unit #(
      .STATE (2'(g))
    ) u_acs (
      .sym_sys  (sym_m[0]),
      .sym_p1   (sym_m[1]),
      .sym_p2   (sym_m[2]),
      .pm_lo    (pm[2*(g%2)]),
      .pm_hi    (pm[2*(g%2)+1]),
      .pm_new   (pm_next[g]),
      .decision (dec[g])
    );
  end

  // Path metrics sit at their start values outside ACS so every frame
  // begins from state 0; during ACS one trellis step is applied per cycle
  // and its four decision bits are stored for traceback.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      step <= '0;
      for (int s = 0; s < N_STATES; s++) begin
        pm[s] <= (s == 0) ? '0 : METRIC_INIT;
      end
      for (int t = 0; t < N_STEPS; t++) begin
        surv[t] <= '0;
      end
    end else if (state == ACS) begin
      step       <= (step == STEP_LAST) ? '0 : step + 3'd1;
      surv[step] <= dec;
      for (int s = 0; s < N_STATES; s++) begin
        pm[s] <= pm_next[s];
      end
    end else begin
      step <= '0;
      for (int s = 0; s < N_STATES; s++) begin
        pm[s] <= (s == 0) ? '0 : METRIC_INIT;
      end
    end
  end

  // Traceback from terminal state 0. The input bit of each step is the MSB
  // of the state it lands in; the decision bit recovers the old m0. Tail
  // steps need no special handling because paths into state 0 at the end
  // are forced through u=0 by the trellis itself.
  always_comb begin
    trace_state = 2'b00;
    info_bits   = '0;
    for (int t = N_STEPS - 1; t >= 0; t--) begin
      if (t < INFO_W) info_bits[t] = trace_state[1];
      trace_state = {trace_state[0], surv[t][trace_state]};
    end
  end

  // Result register: data_o and done_o change together on the TRACE edge,
  // and data_o keeps its value until the next result.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_o <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= (state == TRACE);
      if (state == TRACE) data_o <= info_bits;
    end
  end

endmodule

// File: tb/tb_deco.sv
// Self-checking bench for deco: directed frames built by a small encoder,
// with hand-chosen info patterns as expected results.
module tb_deco;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [20:0] data = '0;
  logic [4:0]  dout;
  logic        done;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] SYM_POS = 4'b0111;
  localparam logic [3:0] SYM_NEG = 4'b1001;

  always #5 clk = ~clk;

  deco dut (
    .clk_p_i   (clk),
    .reset_n_i (reset_n),
    .start_i   (start),
    .data_i    (data),
    .data_o    (dout),
    .done_o    (done)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Encode 5 info bits + 2 zero tail bits into an 84-bit frame of +/-7
  // symbols; flip_step >= 0 inverts the p1 symbol of that step.
  function automatic logic [83:0] build_frame(input logic [4:0] info, input int flip_step);
    logic [83:0] f;
    logic [1:0]  st;
    logic        u, c0, c1, c2;
    f  = '0;
    st = 2'b00;
    for (int t = 0; t < 7; t++) begin
      u  = (t < 5) ? info[t] : 1'b0;
      c0 = u;
      c1 = u ^ st[1] ^ st[0];
      c2 = u ^ st[0];
      if (t == flip_step) c1 = ~c1;
      f[12*t +: 4]   = c0 ? SYM_POS : SYM_NEG;
      f[12*t+4 +: 4] = c1 ? SYM_POS : SYM_NEG;
      f[12*t+8 +: 4] = c2 ? SYM_POS : SYM_NEG;
      st = {u, st[1]};
    end
    return f;
  endfunction

  // Starts and ends on a falling edge; drives n_words words (word 3 is
  // repeated beyond the fourth) and then drops start.
  task automatic applyStimulus(input logic [83:0] frame, input int n_words);
    int idx;
    for (int w = 0; w < n_words; w++) begin
      idx   = (w < 4) ? w : 3;
      start = 1'b1;
      data  = frame[idx*21 +: 21];
      @(negedge clk);
    end
    start = 1'b0;
    data  = '0;
  endtask

  // Observes one decode: latency counted from the edge that samples
  // start low, pulse width, result and hold after the pulse.
  task automatic runDecode(input string tag, input logic [4:0] expected);
    int         lat;
    int         pulses;
    logic [4:0] captured;
    lat      = -1;
    pulses   = 0;
    captured = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat      = c;
          captured = dout;
        end
      end else if (lat >= 0) begin
        break;
      end
    end
    checkOutput({tag, "_latency"}, lat, 8);
    checkOutput({tag, "_pulses"}, pulses, 1);
    checkOutput({tag, "_data"}, {27'd0, captured}, {27'd0, expected});
    checkOutput({tag, "_hold"}, {27'd0, dout}, {27'd0, expected});
  endtask

  task automatic watchNoDone(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput({tag, "_no_done"}, pulses, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset_done", {31'd0, done}, 0);
    checkOutput("reset_data", {27'd0, dout}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    applyStimulus({21{4'b1001}}, 4);
    runDecode("all_neg7", 5'b00000);

    applyStimulus(build_frame(5'b10110, -1), 4);
    runDecode("info_10110", 5'b10110);

    applyStimulus(build_frame(5'b11111, 2), 4);
    runDecode("flip_p1", 5'b11111);

    applyStimulus(build_frame(5'b01101, -1), 5);
    runDecode("hold5_a", 5'b01101);
    applyStimulus(build_frame(5'b10011, -1), 4);
    runDecode("b2b_b", 5'b10011);

    applyStimulus(build_frame(5'b01010, -1), 4);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_done", {31'd0, done}, 0);
    checkOutput("abort_data", {27'd0, dout}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    watchNoDone("abort", 14);
    checkOutput("abort_data_after", {27'd0, dout}, 0);

    applyStimulus(build_frame(5'b00001, -1), 4);
    runDecode("post_reset", 5'b00001);

    applyStimulus(build_frame(5'b11100, -1), 2);
    watchNoDone("short_load", 14);
    checkOutput("short_load_hold", {27'd0, dout}, {27'd0, 5'b00001});

    applyStimulus(build_frame(5'b11000, -1), 4);
    runDecode("after_short", 5'b11000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
